// File: rtl/cnn_layer_accel_pkg.sv
// Shared definitions for the CNN layer accelerator job controller.
//   - NumCfgLanesDefault : default number of one-hot config lanes on the quad
//   - WordWidth          : width of job descriptors and config words
//   - job_state_e        : job controller FSM states
//   - lane_width()       : lane-index width for a given lane count (minimum 1 bit)
package cnn_layer_accel_pkg;

    localparam int unsigned NumCfgLanesDefault = 4;
    localparam int unsigned WordWidth          = 128;
    localparam int unsigned JobCountWidth      = 16;

    typedef logic [WordWidth-1:0] word_t;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StWaitFetch,
        StCfg,
        StFetchDone,
        StRun,
        StAck
    } job_state_e;

    function automatic int unsigned lane_width(input int unsigned lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/cnn_layer_accel_job_ctrl_if.sv
// Bundle of all host, config-stream and quad signals of the job controller.
//   master : used by the controller (drives ready/job/config/status outputs)
//   slave  : used by the environment (drives host, config stream and quad responses)
// Host:   host_job_valid/ready, host_job_params
// Stream: cfg_in_valid/ready, cfg_in_data, cfg_in_last
// Quad:   job_start, job_parameters, job_accept, job_fetch_request, job_fetch_ack,
//         job_fetch_complete, job_complete, job_complete_ack,
//         config_valid, config_accept, config_data
// Status: job_done, job_error, job_count
interface cnn_layer_accel_job_ctrl_if #(
    parameter int unsigned NUM_CFG_LANES = cnn_layer_accel_pkg::NumCfgLanesDefault
);
    import cnn_layer_accel_pkg::*;

    logic                     host_job_valid;
    logic                     host_job_ready;
    word_t                    host_job_params;

    logic                     cfg_in_valid;
    logic                     cfg_in_ready;
    word_t                    cfg_in_data;
    logic                     cfg_in_last;

    logic                     job_start;
    word_t                    job_parameters;
    logic                     job_accept;
    logic                     job_fetch_request;
    logic                     job_fetch_ack;
    logic                     job_fetch_complete;
    logic                     job_complete;
    logic                     job_complete_ack;

    logic [NUM_CFG_LANES-1:0] config_valid;
    logic [NUM_CFG_LANES-1:0] config_accept;
    word_t                    config_data;

    logic                     job_done;
    logic                     job_error;
    logic [JobCountWidth-1:0] job_count;

    modport master (
        input  host_job_valid, host_job_params,
        input  cfg_in_valid, cfg_in_data, cfg_in_last,
        input  job_accept, job_fetch_request, job_complete, config_accept,
        output host_job_ready, cfg_in_ready,
        output job_start, job_parameters, job_fetch_ack, job_fetch_complete, job_complete_ack,
        output config_valid, config_data,
        output job_done, job_error, job_count
    );

    modport slave (
        output host_job_valid, host_job_params,
        output cfg_in_valid, cfg_in_data, cfg_in_last,
        output job_accept, job_fetch_request, job_complete, config_accept,
        input  host_job_ready, cfg_in_ready,
        input  job_start, job_parameters, job_fetch_ack, job_fetch_complete, job_complete_ack,
        input  config_valid, config_data,
        input  job_done, job_error, job_count
    );

endinterface

// File: rtl/cnn_layer_accel_cfg_router.sv
// Config word register and lane rotation.
// Holds one config word at a time and presents it on the current lane as a one-hot
// valid until the quad accepts it on that same lane; accepts on other lanes are ignored
// because only the selected valid bit can be matched. The lane advances modulo
// NUM_CFG_LANES on each quad accept and returns to 0 on clear_i.
// Ports:
//   clk_i, rst_i     : clock, asynchronous active-high reset
//   clear_i          : drop any pending word and restart at lane 0
//   load_i           : capture data_i/last_i (only asserted while nothing is pending)
//   accept_i         : per-lane accept from the quad
//   valid_o, data_o  : one-hot lane valid and registered word
//   pending_o        : a word is waiting for the quad
//   last_done_o      : the quad accepted the word tagged last
module cnn_layer_accel_cfg_router
    import cnn_layer_accel_pkg::*;
#(
    parameter int unsigned NUM_CFG_LANES = NumCfgLanesDefault
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     load_i,
    input  word_t                    data_i,
    input  logic                     last_i,
    input  logic [NUM_CFG_LANES-1:0] accept_i,
    output logic [NUM_CFG_LANES-1:0] valid_o,
    output word_t                    data_o,
    output logic                     pending_o,
    output logic                     last_done_o
);

    localparam int unsigned LaneW = lane_width(NUM_CFG_LANES);

    logic [LaneW-1:0]         lane_q;
    logic [NUM_CFG_LANES-1:0] valid_q;
    logic [NUM_CFG_LANES-1:0] lane_sel;
    word_t                    data_q;
    logic                     last_q;
    logic                     hit;

    always_comb begin
        lane_sel = '0;
        for (int i = 0; i < NUM_CFG_LANES; i++) begin
            lane_sel[i] = (lane_q == LaneW'(i));
        end
    end

    // valid_q is one-hot on the selected lane, so only that lane's accept can match.
    assign hit = |(valid_q & accept_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lane_q  <= '0;
            valid_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
        end else if (clear_i) begin
            lane_q  <= '0;
            valid_q <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            data_q  <= data_i;
            last_q  <= last_i;
            valid_q <= lane_sel;
        end else if (hit) begin
            valid_q <= '0;
            lane_q  <= (lane_q == LaneW'(NUM_CFG_LANES - 1)) ? '0 : lane_q + LaneW'(1);
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign pending_o   = |valid_q;
    assign last_done_o = hit && last_q;

endmodule

// File: rtl/cnn_layer_accel_job_ctrl.sv
// Job controller between a host job queue, a config word stream and one compute quad.
// Sequence per job: accept descriptor, start the quad, acknowledge its fetch request,
// stream config words round-robin over the config lanes, signal fetch complete, wait
// for job completion, acknowledge it, then pulse job_done and count the job.
// Ports:
//   clk_if : sole clock, rising edge
//   rst    : asynchronous active-high reset; abandons any job without a done/error pulse
//   bus    : cnn_layer_accel_job_ctrl_if.master (host, config stream, quad and status)
// Optional build macro CNN_JOB_CTRL_TIMEOUT_EN: watchdog over START, WAIT_FETCH, CFG and
// RUN; after TIMEOUT_CYCLES cycles in one state the job is dropped and job_error pulses.
// Without it job_error is tied low and every state waits indefinitely.
module cnn_layer_accel_job_ctrl
    import cnn_layer_accel_pkg::*;
#(
    parameter int unsigned NUM_CFG_LANES  = NumCfgLanesDefault,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input logic                         clk_if,
    input logic                         rst,
    cnn_layer_accel_job_ctrl_if.master  bus
);

    if (TIMEOUT_CYCLES == 0 || NUM_CFG_LANES == 0) begin : g_param_check
        $error("cnn_layer_accel_job_ctrl: TIMEOUT_CYCLES and NUM_CFG_LANES must be non-zero");
    end

    job_state_e               state_q;
    logic                     host_job_ready_q;
    logic                     job_start_q;
    word_t                    job_parameters_q;
    logic                     job_fetch_ack_q;
    logic                     job_fetch_complete_q;
    logic                     job_complete_ack_q;
    logic                     job_done_q;
    logic [JobCountWidth-1:0] job_count_q;

    logic job_take;
    logic cfg_rdy;
    logic cfg_load;
    logic cfg_pending;
    logic cfg_last_done;
    logic cfg_clear;
    logic abort;

    assign job_take = (state_q == StIdle) && host_job_ready_q && bus.host_job_valid;
    assign cfg_rdy  = (state_q == StCfg) && !cfg_pending;
    assign cfg_load = cfg_rdy && bus.cfg_in_valid;
    // Lane restarts at 0 for every job; an aborted job drops its pending word.
    assign cfg_clear = job_take || abort;

    cnn_layer_accel_cfg_router #(
        .NUM_CFG_LANES (NUM_CFG_LANES)
    ) u_cfg_router (
        .clk_i       (clk_if),
        .rst_i       (rst),
        .clear_i     (cfg_clear),
        .load_i      (cfg_load),
        .data_i      (bus.cfg_in_data),
        .last_i      (bus.cfg_in_last),
        .accept_i    (bus.config_accept),
        .valid_o     (bus.config_valid),
        .data_o      (bus.config_data),
        .pending_o   (cfg_pending),
        .last_done_o (cfg_last_done)
    );

`ifdef CNN_JOB_CTRL_TIMEOUT_EN
    logic [31:0] tmo_q;
    logic        counting;
    logic        advance;
    logic        job_error_q;

    assign counting = (state_q == StStart) || (state_q == StWaitFetch) ||
                      (state_q == StCfg)   || (state_q == StRun);

    // Leaving state this cycle; the counter restarts in the next state.
    always_comb begin
        advance = 1'b0;
        unique case (state_q)
            StStart:     advance = bus.job_accept;
            StWaitFetch: advance = bus.job_fetch_request;
            StCfg:       advance = cfg_last_done;
            StRun:       advance = bus.job_complete;
            default:     advance = 1'b0;
        endcase
    end

    assign abort = counting && !advance && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            tmo_q       <= '0;
            job_error_q <= 1'b0;
        end else begin
            job_error_q <= abort;
            if (!counting || advance || abort) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 32'd1;
            end
        end
    end

    assign bus.job_error = job_error_q;
`else
    assign abort         = 1'b0;
    assign bus.job_error = 1'b0;
`endif

    always_ff @(posedge clk_if or posedge rst) begin
        if (rst) begin
            state_q              <= StIdle;
            host_job_ready_q     <= 1'b0;
            job_start_q          <= 1'b0;
            job_parameters_q     <= '0;
            job_fetch_ack_q      <= 1'b0;
            job_fetch_complete_q <= 1'b0;
            job_complete_ack_q   <= 1'b0;
            job_done_q           <= 1'b0;
            job_count_q          <= '0;
        end else begin
            job_fetch_ack_q      <= 1'b0;
            job_fetch_complete_q <= 1'b0;
            job_done_q           <= 1'b0;
            if (abort) begin
                state_q            <= StIdle;
                host_job_ready_q   <= 1'b0;
                job_start_q        <= 1'b0;
                job_complete_ack_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        // Ready is registered, so it stays low in the job_done cycle.
                        if (job_take) begin
                            job_parameters_q <= bus.host_job_params;
                            job_start_q      <= 1'b1;
                            host_job_ready_q <= 1'b0;
                            state_q          <= StStart;
                        end else begin
                            host_job_ready_q <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (bus.job_accept) begin
                            job_start_q <= 1'b0;
                            state_q     <= StWaitFetch;
                        end
                    end
                    StWaitFetch: begin
                        if (bus.job_fetch_request) begin
                            job_fetch_ack_q <= 1'b1;
                            state_q         <= StCfg;
                        end
                    end
                    StCfg: begin
                        if (cfg_last_done) begin
                            job_fetch_complete_q <= 1'b1;
                            state_q              <= StFetchDone;
                        end
                    end
                    StFetchDone: begin
                        state_q <= StRun;
                    end
                    StRun: begin
                        if (bus.job_complete) begin
                            job_complete_ack_q <= 1'b1;
                            state_q            <= StAck;
                        end
                    end
                    StAck: begin
                        if (!bus.job_complete) begin
                            job_complete_ack_q <= 1'b0;
                            job_done_q         <= 1'b1;
                            job_count_q        <= job_count_q + JobCountWidth'(1);
                            state_q            <= StIdle;
                        end
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.host_job_ready     = host_job_ready_q;
    assign bus.cfg_in_ready       = cfg_rdy;
    assign bus.job_start          = job_start_q;
    assign bus.job_parameters     = job_parameters_q;
    assign bus.job_fetch_ack      = job_fetch_ack_q;
    assign bus.job_fetch_complete = job_fetch_complete_q;
    assign bus.job_complete_ack   = job_complete_ack_q;
    assign bus.job_done           = job_done_q;
    assign bus.job_count          = job_count_q;

endmodule

// File: tb/tb_cnn_layer_accel_job_ctrl.sv
// Directed bench for cnn_layer_accel_job_ctrl. Config words are pushed to a scoreboard
// with their expected lane when driven and popped when the DUT presents them.
// Define CNN_JOB_CTRL_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYCLES=16).
module tb_cnn_layer_accel_job_ctrl;
    import cnn_layer_accel_pkg::*;

    localparam int unsigned NL = 4;
`ifdef CNN_JOB_CTRL_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 65535;
`endif

    typedef struct {
        logic [NL-1:0] valid;
        word_t         data;
    } cfg_exp_t;

    logic clk_if = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_if = ~clk_if;

    cnn_layer_accel_job_ctrl_if #(.NUM_CFG_LANES(NL)) bus ();

    cnn_layer_accel_job_ctrl #(
        .NUM_CFG_LANES  (NL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_if (clk_if),
        .rst    (rst),
        .bus    (bus)
    );

    int       checks = 0;
    int       errors = 0;
    int       exp_count = 0;
    cfg_exp_t sb[$];

    int n_fack = 0;
    int n_fcmp = 0;
    int n_done = 0;
    int n_err  = 0;

    always @(negedge clk_if) begin
        if (bus.job_fetch_ack)      n_fack++;
        if (bus.job_fetch_complete) n_fcmp++;
        if (bus.job_done)           n_done++;
        if (bus.job_error)          n_err++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench time limit");
    end

    task automatic tick();
        @(negedge clk_if);
    endtask

    function automatic word_t rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic host_start(input word_t p, input int d);
        int   hi;
        logic stable;
        chk("idle_ready", bus.host_job_ready, 1);
        bus.host_job_valid  = 1'b1;
        bus.host_job_params = p;
        tick();
        bus.host_job_valid  = 1'b0;
        bus.host_job_params = rand128();
        chk("start_latency", bus.job_start, 1);
        chk("ready_low_busy", bus.host_job_ready, 0);
        hi     = 0;
        stable = 1'b1;
        for (int c = 0; c < 200 && bus.job_start; c++) begin
            hi++;
            if (bus.job_parameters !== p) stable = 1'b0;
            bus.job_accept = (hi == d + 1);
            tick();
        end
        bus.job_accept = 1'b0;
        chk("start_cycles", hi, d + 1);
        chk("params_stable", stable, 1);
    endtask

    task automatic fetch();
        // Responses outside their waiting state must be ignored.
        bus.job_accept   = 1'b1;
        bus.job_complete = 1'b1;
        tick();
        tick();
        bus.job_accept   = 1'b0;
        bus.job_complete = 1'b0;
        chk("stray_no_ack", bus.job_fetch_ack, 0);
        chk("stray_no_cfg", bus.cfg_in_ready, 0);
        bus.job_fetch_request = 1'b1;
        tick();
        bus.job_fetch_request = 1'b0;
        chk("fetch_ack_pulse", bus.job_fetch_ack, 1);
        tick();
        chk("fetch_ack_once", bus.job_fetch_ack, 0);
    endtask

    task automatic send_cfg(input int n, input bit bad);
        cfg_exp_t e;
        cfg_exp_t got;
        int       lane;
        lane = 0;
        for (int w = 0; w < n; w++) begin
            for (int c = 0; c < 50 && !bus.cfg_in_ready; c++) tick();
            chk("cfg_ready", bus.cfg_in_ready, 1);
            e.data        = rand128();
            e.valid       = '0;
            e.valid[lane] = 1'b1;
            sb.push_back(e);
            bus.cfg_in_valid = 1'b1;
            bus.cfg_in_data  = e.data;
            bus.cfg_in_last  = (w == n - 1);
            tick();
            bus.cfg_in_valid = 1'b0;
            bus.cfg_in_last  = 1'b0;
            bus.cfg_in_data  = rand128();
            chk("cfg_ready_busy", bus.cfg_in_ready, 0);
            for (int c = 0; c < 50 && bus.config_valid == '0; c++) tick();
            got = sb.pop_front();
            chk("cfg_valid_lane", bus.config_valid, got.valid);
            chk("cfg_data", bus.config_data, got.data);
            if (bad && lane == 0) begin
                bus.config_accept    = '0;
                bus.config_accept[2] = 1'b1;
                tick();
                tick();
                bus.config_accept = '0;
                chk("wrong_lane_hold", bus.config_valid, got.valid);
                chk("wrong_lane_data", bus.config_data, got.data);
            end
            bus.config_accept = got.valid;
            tick();
            bus.config_accept = '0;
            lane = (lane + 1) % NL;
        end
        chk("cfg_valid_clear", bus.config_valid, 0);
        chk("fetch_complete_pulse", bus.job_fetch_complete, 1);
        tick();
        chk("fetch_complete_once", bus.job_fetch_complete, 0);
    endtask

    task automatic complete(input int h);
        bus.job_complete = 1'b1;
        for (int i = 0; i < h; i++) begin
            tick();
            chk("complete_ack_high", bus.job_complete_ack, 1);
            chk("no_early_done", bus.job_done, 0);
        end
        bus.job_complete = 1'b0;
        tick();
        exp_count = (exp_count + 1) % 65536;
        chk("complete_ack_low", bus.job_complete_ack, 0);
        chk("job_done_pulse", bus.job_done, 1);
        chk("job_count", bus.job_count, exp_count);
        chk("ready_low_done", bus.host_job_ready, 0);
        tick();
        chk("job_done_once", bus.job_done, 0);
        chk("ready_after_done", bus.host_job_ready, 1);
    endtask

    task automatic run_job(input word_t p, input int n, input int d, input int h, input bit bad);
        int fa0, fc0, dn0, er0;
        fa0 = n_fack;
        fc0 = n_fcmp;
        dn0 = n_done;
        er0 = n_err;
        host_start(p, d);
        fetch();
        send_cfg(n, bad);
        complete(h);
        chk("fetch_ack_count", n_fack - fa0, 1);
        chk("fetch_cmpl_count", n_fcmp - fc0, 1);
        chk("done_count", n_done - dn0, 1);
        chk("error_count", n_err - er0, 0);
    endtask

    initial begin
        logic [NL-1:0] lane0;
        int            dn0, er0, fc0;
        lane0    = '0;
        lane0[0] = 1'b1;

        bus.host_job_valid    = 1'b0;
        bus.host_job_params   = '0;
        bus.cfg_in_valid      = 1'b0;
        bus.cfg_in_data       = '0;
        bus.cfg_in_last       = 1'b0;
        bus.job_accept        = 1'b0;
        bus.job_fetch_request = 1'b0;
        bus.job_complete      = 1'b0;
        bus.config_accept     = '0;

        // Reset values.
        tick();
        tick();
        chk("rst_ready", bus.host_job_ready, 0);
        chk("rst_start", bus.job_start, 0);
        chk("rst_params", bus.job_parameters, 0);
        chk("rst_cfg_valid", bus.config_valid, 0);
        chk("rst_cfg_data", bus.config_data, 0);
        chk("rst_count", bus.job_count, 0);
        chk("rst_error", bus.job_error, 0);
        rst = 1'b0;
        tick();
        chk("ready_after_rst", bus.host_job_ready, 1);

        // Reset while a config word waits in CFG.
        dn0 = n_done;
        er0 = n_err;
        fc0 = n_fcmp;
        host_start(rand128(), 0);
        fetch();
        for (int c = 0; c < 50 && !bus.cfg_in_ready; c++) tick();
        bus.cfg_in_valid = 1'b1;
        bus.cfg_in_data  = rand128();
        bus.cfg_in_last  = 1'b1;
        tick();
        bus.cfg_in_valid = 1'b0;
        bus.cfg_in_last  = 1'b0;
        chk("pre_rst_cfg_valid", bus.config_valid, lane0);
        rst = 1'b1;
        #1;
        chk("mid_rst_cfg_valid", bus.config_valid, 0);
        chk("mid_rst_cfg_data", bus.config_data, 0);
        chk("mid_rst_cfg_ready", bus.cfg_in_ready, 0);
        chk("mid_rst_ready", bus.host_job_ready, 0);
        chk("mid_rst_params", bus.job_parameters, 0);
        chk("mid_rst_count", bus.job_count, exp_count);
        tick();
        rst = 1'b0;
        tick();
        chk("ready_after_mid_rst", bus.host_job_ready, 1);
        tick();
        chk("mid_rst_no_done", n_done - dn0, 0);
        chk("mid_rst_no_error", n_err - er0, 0);
        chk("mid_rst_no_fcmp", n_fcmp - fc0, 0);

        // Five words, immediate accepts: lanes 0,1,2,3,0.
        run_job(rand128(), 5, 0, 1, 1'b0);
        // Delayed job_accept, wrong-lane accept, job_complete held four cycles.
        run_job(rand128(), 3, 10, 4, 1'b1);
        run_job(rand128(), 2, 2, 2, 1'b0);

`ifdef CNN_JOB_CTRL_TIMEOUT_EN
        begin
            int k;
            dn0 = n_done;
            er0 = n_err;
            host_start(rand128(), 0);
            fetch();
            send_cfg(1, 1'b0);
            k = 0;
            for (int c = 0; c < 100 && !bus.job_error; c++) begin
                tick();
                k++;
            end
            chk("tmo_cycles", k, TMO);
            chk("tmo_error", bus.job_error, 1);
            chk("tmo_count", bus.job_count, exp_count);
            chk("tmo_no_ack", bus.job_complete_ack, 0);
            chk("tmo_ready_low", bus.host_job_ready, 0);
            tick();
            chk("tmo_error_once", bus.job_error, 0);
            chk("tmo_ready", bus.host_job_ready, 1);
            chk("tmo_no_done", n_done - dn0, 0);
            chk("tmo_err_count", n_err - er0, 1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cnn_layer_accel_job_ctrl.md
CNN_LAYER_ACCEL_JOB_CTRL -- requirements
Module: cnn_layer_accel_job_ctrl

Interface
REQ-001 SHALL have parameter NUM_CFG_LANES, default 4, number of one-hot config lanes on the quad.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535, watchdog limit in clk_if cycles.
REQ-003 SHALL use one clock and an asynchronous, active-high reset, named as below.
REQ-004 clk_if  in  1  sole clock; all state updates on its rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 host_job_valid / host_job_ready  in/out  1/1  job descriptor handshake.
REQ-007 host_job_params  in  128  descriptor forwarded as job_parameters.
REQ-008 cfg_in_valid / cfg_in_ready  in/out  1/1  config word stream handshake.
REQ-009 cfg_in_data / cfg_in_last  in  128/1  config word; last word of job.
REQ-010 job_start, job_parameters[127:0], job_fetch_ack, job_fetch_complete, job_complete_ack  out  quad job controls.
REQ-011 job_accept, job_fetch_request, job_complete  in  1  quad job responses.
REQ-012 config_valid  out  NUM_CFG_LANES;  config_accept  in  NUM_CFG_LANES;  config_data  out  128.
REQ-013 job_done / job_error  out  1/1  one-cycle completion / timeout pulses.
REQ-014 job_count  out  16  completed-job counter.

Function
REQ-015 SHALL implement states IDLE, START, WAIT_FETCH, CFG, FETCH_DONE, RUN, ACK.
REQ-016 IDLE: host_job_ready=1; on host_job_valid, register host_job_params, go START next cycle.
REQ-017 START: job_start=1 with registered job_parameters, held until job_accept sampled 1; next state WAIT_FETCH, job_start 0 from that cycle.
REQ-018 WAIT_FETCH: on job_fetch_request=1, job_fetch_ack SHALL pulse exactly one cycle; next state CFG.
REQ-019 CFG: cfg_in_ready=1 only when no config word pending; accepted word registered to config_data, config_valid one-hot at current lane, held until config_accept[lane]=1.
REQ-020 Lane index SHALL start at 0 per job and increment modulo NUM_CFG_LANES per accepted word (3 wraps to 0).
REQ-021 When the word tagged cfg_in_last is accepted by the quad, SHALL go FETCH_DONE; config_valid all zero next cycle.
REQ-022 config_accept on a non-selected lane SHALL be ignored.
REQ-023 FETCH_DONE: job_fetch_complete pulses one cycle; next state RUN.
REQ-024 RUN: on job_complete=1, go ACK; job_complete_ack=1 held while in ACK.
REQ-025 ACK: when job_complete sampled 0, job_complete_ack 0, job_done pulses one cycle, job_count increments (wraps 0xFFFF->0), state IDLE.
REQ-026 A new host job SHALL not be accepted in the cycle job_done pulses; host_job_ready rises the following cycle.
REQ-027 Inputs job_accept/job_fetch_request/job_complete outside their waiting state SHALL be ignored.
REQ-028 Latency host_job_valid accept -> job_start asserted: 1 cycle.

Reset
REQ-029 On rst: state IDLE, all outputs 0 except host_job_ready=1 only after rst deasserts; job_parameters, config_data, job_count 0; lane index 0.
REQ-030 rst mid-job SHALL abandon the job immediately with no job_done/job_error pulse.

Configuration
REQ-031 With CNN_JOB_CTRL_TIMEOUT_EN defined: a counter cleared on each state change counts in START, WAIT_FETCH, CFG, RUN; reaching TIMEOUT_CYCLES SHALL pulse job_error, drop all job/config outputs, return IDLE without incrementing job_count.
REQ-032 Without CNN_JOB_CTRL_TIMEOUT_EN: no counter logic; job_error tied 0; states wait indefinitely.

Structure
REQ-033 State enum, NUM_CFG_LANES default and 128-bit word width SHALL live in shared package cnn_layer_accel_pkg.
REQ-034 Optional sub-module cnn_layer_accel_cfg_router SHALL hold the config word register and lane rotation; no other sub-modules.

Verification
REQ-035 Single job, 5 config words, immediate accepts -> config_valid 0001,0010,0100,1000,0001; one fetch_ack, one fetch_complete, job_done, job_count=1.
REQ-036 job_accept delayed 10 cycles -> job_start high exactly 10 cycles plus acceptance cycle, job_parameters stable throughout.
REQ-037 config_accept on lane 2 while lane 0 selected -> ignored; word held until config_accept[0].
REQ-038 job_complete held 4 cycles -> job_complete_ack high those cycles, job_done one cycle after job_complete falls.
REQ-039 rst asserted in CFG state -> next edge all outputs 0, no job_done, job_count unchanged.
REQ-040 With CNN_JOB_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, no job_complete -> job_error pulses after 16 RUN cycles, state IDLE, job_count unchanged.
